// File: rtl/fp_group_aligner_if.sv
// Stream bundle for fp_group_aligner: element input stream and aligned output stream.
// The aligner sits on the slave side; the producer/consumer side uses master.
interface fp_group_aligner_if #(
  parameter int EXP_WIDTH     = 5,
  parameter int MAN_IN_WIDTH  = 10,
  parameter int MAN_OUT_WIDTH = 15
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sign;
  logic [EXP_WIDTH-1:0]     in_exp;
  logic [MAN_IN_WIDTH-1:0]  in_man;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_sign;
  logic [MAN_OUT_WIDTH-1:0] out_man;
  logic [EXP_WIDTH-1:0]     out_exp;
  logic                     out_last;

  modport slave (
    input  in_valid, in_sign, in_exp, in_man, out_ready,
    output in_ready, out_valid, out_sign, out_man, out_exp, out_last
  );

  modport master (
    output in_valid, in_sign, in_exp, in_man, out_ready,
    input  in_ready, out_valid, out_sign, out_man, out_exp, out_last
  );
endinterface

// File: rtl/fp_group_aligner.sv
// Collects GROUP floating-point values, then emits them right-aligned to the group's max exponent.
// Optional FP_ALIGNER_STICKY_EN: jam all shifted-out bits into out_man[0].
module fp_group_aligner #(
  parameter int EXP_WIDTH     = 5,
  parameter int MAN_IN_WIDTH  = 10,
  parameter int MAN_OUT_WIDTH = 15,
  parameter int INT_LEN       = 4,
  parameter int GROUP         = 8
) (
  input logic               clk,
  input logic               rst_n,
  fp_group_aligner_if.slave bus
);
  localparam int CNT_W   = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam int ENTRY_W = 1 + EXP_WIDTH + MAN_IN_WIDTH;
  localparam int PAD     = MAN_OUT_WIDTH - INT_LEN - MAN_IN_WIDTH;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [EXP_WIDTH-1:0]   max_exp_reg, max_exp_next;
  logic [ENTRY_W-1:0]     buf_mem [GROUP];

  logic                   in_hs, out_hs, at_last;
  logic                   sel_sign;
  logic [EXP_WIDTH-1:0]   sel_exp;
  logic [MAN_IN_WIDTH-1:0] sel_man;
  logic [EXP_WIDTH-1:0]   shift_d;
  logic                   shift_all;
  logic [MAN_OUT_WIDTH-1:0] u_man, shifted_man, aligned_man;

  assign bus.in_ready  = (state_reg == FILL);
  assign bus.out_valid = (state_reg == DRAIN);
  assign in_hs   = bus.in_valid && (state_reg == FILL);
  assign out_hs  = bus.out_ready && (state_reg == DRAIN);
  assign at_last = (cnt_reg == CNT_W'(GROUP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FILL;
      cnt_reg     <= '0;
      max_exp_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      max_exp_reg <= max_exp_next;
    end
  end

  // Element buffer needs no reset: slots are always written before being read.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      buf_mem[cnt_reg] <= {bus.in_sign, bus.in_exp, bus.in_man};
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    max_exp_next = max_exp_reg;
    case (state_reg)
      FILL: begin
        if (in_hs) begin
          if (bus.in_exp > max_exp_reg) max_exp_next = bus.in_exp;
          if (at_last) begin
            cnt_next   = '0;
            state_next = DRAIN;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (at_last) begin
            cnt_next     = '0;
            max_exp_next = '0;
            state_next   = FILL;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign {sel_sign, sel_exp, sel_man} = buf_mem[cnt_reg];

  // Zero exponent means zero (denormals unsupported), so no hidden 1 is restored.
  assign u_man       = (sel_exp == '0) ? '0
                       : (MAN_OUT_WIDTH'({1'b1, sel_man}) << PAD);
  assign shift_d     = max_exp_reg - sel_exp;
  assign shift_all   = (32'(shift_d) >= MAN_OUT_WIDTH);
  assign shifted_man = shift_all ? '0 : (u_man >> shift_d);

`ifdef FP_ALIGNER_STICKY_EN
  logic [MAN_OUT_WIDTH-1:0] lost_mask;
  logic                     sticky;
  assign lost_mask   = shift_all ? '1 : ~({MAN_OUT_WIDTH{1'b1}} << shift_d);
  assign sticky      = |(u_man & lost_mask);
  assign aligned_man = {shifted_man[MAN_OUT_WIDTH-1:1], shifted_man[0] | sticky};
`else
  assign aligned_man = shifted_man;
`endif

  // Outputs read as zero outside DRAIN so the reset/idle values are well defined.
  assign bus.out_sign = (state_reg == DRAIN) && sel_sign;
  assign bus.out_man  = (state_reg == DRAIN) ? aligned_man : '0;
  assign bus.out_exp  = (state_reg == DRAIN) ? max_exp_reg : '0;
  assign bus.out_last = (state_reg == DRAIN) && at_last;
endmodule

// File: tb/tb_fp_group_aligner.sv
// Directed, table-driven bench for fp_group_aligner with default parameters.
module tb_fp_group_aligner;
  logic clk;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  fp_group_aligner_if #(.EXP_WIDTH(5), .MAN_IN_WIDTH(10), .MAN_OUT_WIDTH(15)) bus ();

  fp_group_aligner #(
    .EXP_WIDTH(5), .MAN_IN_WIDTH(10), .MAN_OUT_WIDTH(15), .INT_LEN(4), .GROUP(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [4:0]  exp;
    logic [9:0]  man;
    logic [14:0] man_trunc;
    logic [14:0] man_sticky;
  } vec_t;

  vec_t       tbl [6][8];
  logic [4:0] grp_exp [6];

  function automatic vec_t mk(logic s, logic [4:0] e, logic [9:0] m,
                              logic [14:0] t, logic [14:0] st);
    vec_t v;
    v.sign = s; v.exp = e; v.man = m; v.man_trunc = t; v.man_sticky = st;
    return v;
  endfunction

  function automatic logic [14:0] want_man(vec_t v);
`ifdef FP_ALIGNER_STICKY_EN
    return v.man_sticky;
`else
    return v.man_trunc;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_out(int g, int i);
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("out_sign",  32'(bus.out_sign),  32'(tbl[g][i].sign));
    chk("out_man",   32'(bus.out_man),   32'(want_man(tbl[g][i])));
    chk("out_exp",   32'(bus.out_exp),   32'(grp_exp[g]));
    chk("out_last",  32'(bus.out_last),  32'(i == 7));
    chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_out_sign",  32'(bus.out_sign),  32'd0);
    chk("rst_out_man",   32'(bus.out_man),   32'd0);
    chk("rst_out_exp",   32'(bus.out_exp),   32'd0);
  endtask

  // Drives n elements of group g; returns on the negedge after the last handshake.
  task automatic send(int g, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("fill_in_ready",  32'(bus.in_ready),  32'd1);
      chk("fill_out_valid", 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_sign  = tbl[g][i].sign;
      bus.in_exp   = tbl[g][i].exp;
      bus.in_man   = tbl[g][i].man;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Consumes n outputs starting at the current negedge, optionally stalling on hold_idx.
  task automatic drain(int g, int n, int hold_idx);
    for (int i = 0; i < n; i++) begin
      if (i == hold_idx) begin
        bus.out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          chk_out(g, i);
          @(negedge clk);
        end
      end
      chk_out(g, i);
      $display("grp %0d out[%0d] sign=%0b man=%04h exp=%0d last=%0b",
               g, i, bus.out_sign, bus.out_man, bus.out_exp, bus.out_last);
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    if (n == 8) begin
      chk("post_in_ready",  32'(bus.in_ready),  32'd1);
      chk("post_out_valid", 32'(bus.out_valid), 32'd0);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    $display("reset pulse at %0t", $time);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Group 0: all 1.0
    for (int i = 0; i < 8; i++) tbl[0][i] = mk(i[0], 5'd15, 10'h000, 15'h0800, 15'h0800);
    grp_exp[0] = 5'd15;
    // Group 1: mixed shifts under max 15
    tbl[1][0] = mk(1'b0, 5'd15, 10'h000, 15'h0800, 15'h0800);
    tbl[1][1] = mk(1'b1, 5'd13, 10'h200, 15'h0300, 15'h0300);
    tbl[1][2] = mk(1'b0, 5'd12, 10'h001, 15'h0100, 15'h0101);
    tbl[1][3] = mk(1'b1, 5'd0,  10'h3FF, 15'h0000, 15'h0000);
    tbl[1][4] = mk(1'b0, 5'd14, 10'h000, 15'h0400, 15'h0400);
    tbl[1][5] = mk(1'b1, 5'd15, 10'h3FF, 15'h0FFE, 15'h0FFE);
    tbl[1][6] = mk(1'b0, 5'd11, 10'h300, 15'h00E0, 15'h00E0);
    tbl[1][7] = mk(1'b1, 5'd10, 10'h001, 15'h0040, 15'h0041);
    grp_exp[1] = 5'd15;
    // Group 2: max 16, full-width shift-out and a zero element
    tbl[2][0] = mk(1'b0, 5'd16, 10'h000, 15'h0800, 15'h0800);
    tbl[2][1] = mk(1'b1, 5'd1,  10'h3FF, 15'h0000, 15'h0001);
    tbl[2][2] = mk(1'b0, 5'd0,  10'h2AA, 15'h0000, 15'h0000);
    for (int i = 3; i < 8; i++) tbl[2][i] = mk(i[0], 5'd9, 10'h000, 15'h0010, 15'h0010);
    grp_exp[2] = 5'd16;
    // Group 3: all-zero exponents
    for (int i = 0; i < 8; i++) tbl[3][i] = mk(i[1], 5'd0, 10'(i * 37 + 1), 15'h0000, 15'h0000);
    grp_exp[3] = 5'd0;
    // Group 4: all exp 10
    for (int i = 0; i < 8; i++) tbl[4][i] = mk(1'b0, 5'd10, 10'h000, 15'h0800, 15'h0800);
    grp_exp[4] = 5'd10;
    // Group 5: residue group with a high exponent, only ever partially loaded
    for (int i = 0; i < 8; i++) tbl[5][i] = mk(1'b1, 5'd20, 10'h155, 15'h0AAA, 15'h0AAA);
    grp_exp[5] = 5'd20;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_man    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    for (int g = 0; g < 4; g++) begin
      send(g, 8);
      drain(g, 8, -1);
    end

    // Backpressure on index 2, then max_exp must have been cleared for the next group
    send(0, 8);
    drain(0, 8, 2);
    send(4, 8);
    drain(4, 8, -1);

    // Abort during fill: no residue of exp 20 may survive
    send(5, 5);
    reset_pulse();
    send(0, 8);
    drain(0, 8, -1);

    // Abort during drain
    send(1, 8);
    drain(1, 3, -1);
    reset_pulse();
    chk("after_rst_out_valid", 32'(bus.out_valid), 32'd0);
    send(2, 8);
    drain(2, 8, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
